// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the BCD scan scheduler.
package bcd_sched_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;

   typedef logic [1:0] ch_t;
   typedef logic [3:0] bcd_digit_t;

   localparam int  NUM_CH = 3;
   localparam ch_t CH_FIR = 2'd0;
   localparam ch_t CH_HH  = 2'd1;
   localparam ch_t CH_MM  = 2'd2;

   // Round-robin successor of a channel index (0 -> 1 -> 2 -> 0).
   function automatic ch_t next_ch(input ch_t ch);
      return (ch == CH_MM) ? CH_FIR : ch + 2'd1;
   endfunction

endpackage

// File: rtl/bcd_serial_core.sv
// Iterative double-dabble converter: one add-3/shift step per cycle.
// 'done' is high while the step about to be applied is the final one,
// so the controller can leave its shift state on that same edge.
module bcd_serial_core
   import bcd_sched_pkg::*;
#(
   parameter int ITER = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic [ITER-1:0] bin,
   output logic            done,
   output logic [3:0]      d2,
   output logic [3:0]      d1,
   output logic [3:0]      d0
);

   localparam int SW = 12 + ITER;
   localparam int CW = $clog2(ITER + 1);

   logic [SW-1:0] sr;
   logic [SW-1:0] sr_adj;
   logic [CW-1:0] cnt;

   // Add 3 to every BCD nibble that is 5 or more before the shift.
   always_comb begin
      // NOTE: default assignment first so every path drives sr_adj and no latch is inferred.
      sr_adj = sr;
      for (int n = 0; n < 3; n++) begin
         if (sr[ITER+4*n +: 4] >= 4'd5)
            sr_adj[ITER+4*n +: 4] = sr[ITER+4*n +: 4] + 4'd3;
      end
   end

   // Shift register and iteration counter.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep register updates order-independent.
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= {12'd0, bin};
         cnt <= '0;
      end else if (step) begin
         sr  <= {sr_adj[SW-2:0], 1'b0};
         cnt <= cnt + 1'b1;
      end
   end

   assign done = (cnt == CW'(ITER - 1));
   assign d2   = sr[ITER+8 +: 4];
   assign d1   = sr[ITER+4 +: 4];
   assign d0   = sr[ITER   +: 4];

endmodule

// File: rtl/bcd_scan_sched.sv
// Round-robin scheduler sharing one serial binary-to-BCD converter
// between the FIR output and the RTC hours/minutes displays.
module bcd_scan_sched
   import bcd_sched_pkg::*;
#(
   parameter int ITER = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] fir_bin,
   input  logic [4:0] hh_bin,
   input  logic [5:0] mm_bin,
   output logic [3:0] fir_d2,
   output logic [3:0] fir_d1,
   output logic [3:0] fir_d0,
   output logic [3:0] hh_d1,
   output logic [3:0] hh_d0,
   output logic [3:0] mm_d1,
   output logic [3:0] mm_d0,
   output logic [2:0] upd,
   output logic       busy
);

   state_t      state;
   ch_t         sel;
   ch_t         last;
   logic [7:0]  in_val [NUM_CH];
   logic [7:0]  shadow [NUM_CH];
   logic [2:0]  pending;
   logic        grant;
   ch_t         gch;
   ch_t         c0, c1, c2;
   logic        load, step, done;
   bcd_digit_t  cd2, cd1, cd0;

   assign in_val[0] = fir_bin;
   assign in_val[1] = {3'd0, hh_bin};
   assign in_val[2] = {2'd0, mm_bin};

   // A channel pends while its input differs from the value last granted.
   always_comb begin
      for (int ch = 0; ch < NUM_CH; ch++)
         pending[ch] = (in_val[ch] != shadow[ch]);
   end

   // Round-robin search starting just after the last served channel.
   always_comb begin
      c0    = next_ch(last);
      c1    = next_ch(c0);
      c2    = next_ch(c1);
      grant = 1'b0;
      gch   = c0;
      if (pending[c0]) begin
         grant = 1'b1;
         gch   = c0;
      end else if (pending[c1]) begin
         grant = 1'b1;
         gch   = c1;
      end else if (pending[c2]) begin
         grant = 1'b1;
         gch   = c2;
      end
   end

   assign load = (state == IDLE) && grant;
   assign step = (state == SHIFT);
   assign busy = (state != IDLE);

   bcd_serial_core #(.ITER(ITER)) u_core (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .step (step),
      .bin  (ITER'(in_val[gch])),
      .done (done),
      .d2   (cd2),
      .d1   (cd1),
      .d0   (cd0)
   );

   // Scheduler FSM, shadows, digit registers and update pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sel   <= CH_FIR;
         last  <= CH_MM;
         upd   <= '0;
         // NOTE: shadows are reset with the rest; a stale shadow would make a zero input look pending.
         for (int ch = 0; ch < NUM_CH; ch++)
            shadow[ch] <= '0;
         fir_d2 <= '0;
         fir_d1 <= '0;
         fir_d0 <= '0;
         hh_d1  <= '0;
         hh_d0  <= '0;
         mm_d1  <= '0;
         mm_d0  <= '0;
      end else begin
         upd <= '0;
         case (state)
            IDLE: begin
               if (grant) begin
                  shadow[gch] <= in_val[gch];
                  sel         <= gch;
                  state       <= SHIFT;
               end
            end
            SHIFT: begin
               if (done)
                  state <= WRITE;
            end
            WRITE: begin
               case (sel)
                  CH_FIR: begin
                     fir_d2 <= cd2;
                     fir_d1 <= cd1;
                     fir_d0 <= cd0;
                  end
                  CH_HH: begin
                     hh_d1 <= cd1;
                     hh_d0 <= cd0;
                  end
                  default: begin
                     mm_d1 <= cd1;
                     mm_d0 <= cd0;
                  end
               endcase
               upd   <= 3'b001 << sel;
               last  <= sel;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_scan_sched.sv
// Scoreboard bench for bcd_scan_sched: stimulus pushes expected writes,
// a negedge monitor pops and compares on every upd pulse.
module tb_bcd_scan_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] fir_bin;
   logic [4:0] hh_bin;
   logic [5:0] mm_bin;
   logic [3:0] fir_d2, fir_d1, fir_d0, hh_d1, hh_d0, mm_d1, mm_d0;
   logic [2:0] upd;
   logic       busy;

   typedef struct {
      logic [2:0]  upd;
      logic [11:0] digits;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   bcd_scan_sched #(.ITER(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .fir_bin (fir_bin),
      .hh_bin  (hh_bin),
      .mm_bin  (mm_bin),
      .fir_d2  (fir_d2),
      .fir_d1  (fir_d1),
      .fir_d0  (fir_d0),
      .hh_d1   (hh_d1),
      .hh_d0   (hh_d0),
      .mm_d1   (mm_d1),
      .mm_d0   (mm_d0),
      .upd     (upd),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] u, input logic [11:0] d);
      exp_t e;
      e.upd    = u;
      e.digits = d;
      q.push_back(e);
   endtask

   // Monitor: every upd pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (upd !== 3'b000) begin
         if (q.size() == 0) begin
            check("unexpected_upd", 32'(upd), 32'd0);
         end else begin
            exp_t       e;
            logic [11:0] act;
            e = q.pop_front();
            case (upd)
               3'b001:  act = {fir_d2, fir_d1, fir_d0};
               3'b010:  act = {4'd0, hh_d1, hh_d0};
               default: act = {4'd0, mm_d1, mm_d0};
            endcase
            check("sb_upd", 32'(upd), 32'(e.upd));
            check("sb_digits", 32'(act), 32'(e.digits));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic quiet;
      int   e_fir, e_hh, e_mm, e_mm2;

      // Reset with all inputs zero: nothing to convert.
      rst = 1'b1; fir_bin = 8'd0; hh_bin = 5'd0; mm_bin = 6'd0;
      tick(); tick();
      rst = 1'b0;
      check("reset_digits", 32'({fir_d2, fir_d1, fir_d0, hh_d1, hh_d0, mm_d1, mm_d0}), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_upd", 32'(upd), 32'd0);
      quiet = 1'b1;
      repeat (20) begin
         tick();
         if (busy !== 1'b0 || upd !== 3'b000) quiet = 1'b0;
      end
      check("idle_quiet_20", 32'(quiet), 32'd1);

      // FIR 0 -> 255: grant at E0, write at E9.
      push(3'b001, 12'h255);
      fir_bin = 8'd255;
      tick();
      check("fir255_busy_e0", 32'(busy), 32'd1);
      repeat (8) tick();
      check("fir255_no_upd_e8", 32'(upd), 32'd0);
      check("fir255_busy_e8", 32'(busy), 32'd1);
      tick();
      check("fir255_upd_e9", 32'(upd), 32'b001);
      check("fir255_busy_e9", 32'(busy), 32'd0);
      tick();
      check("fir255_upd_one_cycle", 32'(upd), 32'd0);

      // Fresh reset so FIR has first priority, then three simultaneous changes.
      rst = 1'b1; fir_bin = 8'd0; hh_bin = 5'd0; mm_bin = 6'd0;
      tick();
      rst = 1'b0;
      push(3'b001, 12'h137);
      push(3'b010, 12'h023);
      push(3'b100, 12'h059);
      fir_bin = 8'd137; hh_bin = 5'd23; mm_bin = 6'd59;
      e_fir = -1; e_hh = -1; e_mm = -1;
      for (int k = 0; k < 35; k++) begin
         tick();
         if (upd == 3'b001) e_fir = k;
         if (upd == 3'b010) e_hh  = k;
         if (upd == 3'b100) e_mm  = k;
      end
      check("rr_fir_edge", 32'(e_fir), 32'd9);
      check("rr_hh_edge", 32'(e_hh), 32'd19);
      check("rr_mm_edge", 32'(e_mm), 32'd29);

      // Fairness: FIR toggles 100/201 every cycle while HH goes 23 -> 12.
      push(3'b001, 12'h100);
      push(3'b010, 12'h012);
      push(3'b001, 12'h201);
      hh_bin = 5'd12; fir_bin = 8'd100;
      e_hh = -1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (upd == 3'b010 && e_hh < 0) e_hh = k;
         if (k <= 24) fir_bin = ((k + 1) % 2 == 0) ? 8'd100 : 8'd201;
      end
      check("hh_fair_within_29", 32'(e_hh >= 0 && e_hh <= 29), 32'd1);
      check("hh_digits_12", 32'({hh_d1, hh_d0}), 32'h12);

      // Minutes change mid-conversion: 10 -> 40 at E0, 41 at E4.
      push(3'b100, 12'h010);
      mm_bin = 6'd10;
      repeat (12) tick();
      push(3'b100, 12'h040);
      push(3'b100, 12'h041);
      mm_bin = 6'd40;
      e_mm = -1; e_mm2 = -1;
      for (int k = 0; k < 25; k++) begin
         tick();
         if (k == 3) mm_bin = 6'd41;
         if (upd == 3'b100) begin
            if (e_mm < 0) e_mm = k;
            else          e_mm2 = k;
         end
      end
      check("mm_first_write_e9", 32'(e_mm), 32'd9);
      check("mm_second_write_e19", 32'(e_mm2), 32'd19);
      check("mm_digits_41", 32'({mm_d1, mm_d0}), 32'h41);

      // Reset at E5 of an FIR conversion aborts it and clears everything.
      fir_bin = 8'd77;
      for (int k = 0; k < 5; k++) tick();
      rst = 1'b1;
      tick();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_upd", 32'(upd), 32'd0);
      check("abort_digits", 32'({fir_d2, fir_d1, fir_d0, hh_d1, hh_d0, mm_d1, mm_d0}), 32'd0);
      rst = 1'b0;
      push(3'b001, 12'h077);
      push(3'b010, 12'h012);
      push(3'b100, 12'h041);
      repeat (35) tick();
      check("post_reset_fir_77", 32'({fir_d2, fir_d1, fir_d0}), 32'h077);

      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
